// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and register map for the MMIO UART transmitter
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 8;

    function automatic logic [31:0] pack_status(
        input logic       full,
        input logic       empty,
        input logic       busy,
        input logic       ovf,
        input logic [7:0] count
    );
        logic [31:0] word;
        word                           = '0;
        word[STAT_FULL]                = full;
        word[STAT_EMPTY]               = empty;
        word[STAT_BUSY]                = busy;
        word[STAT_OVF]                 = ovf;
        word[STAT_COUNT_LSB +: 8]      = count;
        return word;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count, push-on-full accepted when popping
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // a pop in the same cycle frees the slot, so a push on full still lands
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter on the core data-memory store port
`timescale 1ns/1ps
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] RdData,
    output logic        Sel,
    output logic        tx,
    output logic        irq
);

    localparam int             BW          = $clog2(CLKS_PER_BIT);
    localparam int             FCW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0]  BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

    logic           hit;
    logic [1:0]     off;
    logic           push_req;
    logic           push_ok;
    logic           status_wr;
    logic           pop;
    logic [7:0]     fifo_rdata;
    logic           fifo_full;
    logic           fifo_empty;
    logic [FCW-1:0] fifo_count;
    logic           empty_next;

    tx_state_e      state, state_n;
    logic [BW-1:0]  baud_cnt, baud_n;
    logic [2:0]     bit_idx, bit_n;
    logic [7:0]     shift, shift_n;
    logic           tx_n;
    logic           ovf;
    logic           ovf_set;
    logic           ovf_clr;
    logic           busy;
    logic           unused_bits;

    assign hit       = (Addr[31:4] == BASE_ADDR[31:4]);
    assign off       = Addr[3:2];
    assign Sel       = hit;
    assign push_req  = MemWrite && hit && (off == OFF_TXDATA);
    assign status_wr = MemWrite && hit && (off == OFF_STATUS);
    assign push_ok   = push_req && (!fifo_full || pop);
    assign busy      = (state != IDLE);

    assign unused_bits = ^{Addr[1:0], WriteData[31:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .wdata (WriteData[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        RdData = '0;
        if (hit && off == OFF_STATUS) begin
            RdData = pack_status(fifo_full, fifo_empty, busy, ovf, 8'(fifo_count));
        end
    end

    // set beats clear when both land in the same cycle
    assign ovf_set = push_req && fifo_full && !pop;
    assign ovf_clr = status_wr && WriteData[STAT_OVF];

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_rdata;
                    baud_n  = BAUD_RELOAD;
                    state_n = START;
                end
            end
            START: begin
                if (baud_cnt == '0) begin
                    state_n = DATA;
                    baud_n  = BAUD_RELOAD;
                    bit_n   = 3'd0;
                end else begin
                    baud_n = baud_cnt - BW'(1);
                end
            end
            DATA: begin
                if (baud_cnt == '0) begin
                    baud_n  = BAUD_RELOAD;
                    shift_n = {1'b0, shift[7:1]};
                    bit_n   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    baud_n = baud_cnt - BW'(1);
                end
            end
            STOP: begin
                if (baud_cnt == '0) begin
                    // chain straight into the next start bit when more data is queued
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = fifo_rdata;
                        baud_n  = BAUD_RELOAD;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud_cnt - BW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    // irq tracks the post-edge FIFO occupancy so it drops the cycle a byte lands
    assign empty_next = !push_ok && (fifo_empty || (pop && fifo_count == FCW'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            irq      <= 1'b1;
            ovf      <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shift    <= shift_n;
            tx       <= tx_n;
            irq      <= (state_n == IDLE) && empty_next;
            ovf      <= ovf_set || (ovf && !ovf_clr);
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx
`timescale 1ns/1ps
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] A_TX  = 32'h0000_1000;
    localparam logic [31:0] A_ST  = 32'h0000_1004;
    localparam logic [31:0] A_RES = 32'h0000_1008;
    localparam logic [31:0] A_OUT = 32'h0000_1010;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        MemWrite  = 1'b0;
    logic [31:0] Addr      = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] RdData;
    logic        Sel;
    logic        tx;
    logic        irq;

    int   cyc = 0;
    logic txhist  [0:2047];
    logic irqhist [0:2047];
    int   n_checks = 0;
    int   n_fail   = 0;

    mmio_uart_tx #(
        .BASE_ADDR    (32'h0000_1000),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .RdData    (RdData),
        .Sel       (Sel),
        .tx        (tx),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < 2048) begin
            txhist[cyc]  = tx;
            irqhist[cyc] = irq;
        end
    end

    function automatic logic [39:0] frame_bits(input logic [7:0] b);
        logic [39:0] v;
        for (int j = 0; j < FRAME; j++) begin
            if (j < CPB)          v[j] = 1'b0;
            else if (j < 9 * CPB) v[j] = b[(j - CPB) / CPB];
            else                  v[j] = 1'b1;
        end
        return v;
    endfunction

    task automatic gather(input int start, output logic [39:0] v);
        for (int j = 0; j < FRAME; j++) v[j] = txhist[start + j];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        Addr  = A_ST;
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL reset_irq: got %b expected 1", irq); end
        n_checks++;
        if (RdData !== 32'h0000_0002) begin n_fail++; $display("FAIL reset_status: got %h expected 00000002", RdData); end
    endtask

    task automatic test_single_frame();
        int n;
        logic [39:0] v;
        logic irq_low;
        @(negedge clk);
        n = cyc;
        Addr = A_TX; WriteData = 32'h0000_00A5; MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0; Addr = A_ST;
        #1;
        n_checks++;
        if (RdData !== 32'h0000_0100) begin n_fail++; $display("FAIL single_count1: got %h expected 00000100", RdData); end
        repeat (45) @(negedge clk);
        gather(n + 2, v);
        n_checks++;
        if (v !== 40'hFF0F00F0F0) begin n_fail++; $display("FAIL single_frame_a5: got %h expected ff0f00f0f0", v); end
        n_checks++;
        if (txhist[n + 1] !== 1'b1) begin n_fail++; $display("FAIL single_pre_start: got %b expected 1", txhist[n + 1]); end
        irq_low = 1'b1;
        for (int c = n + 1; c <= n + 41; c++) if (irqhist[c] !== 1'b0) irq_low = 1'b0;
        n_checks++;
        if (irq_low !== 1'b1) begin n_fail++; $display("FAIL single_irq_during: got %b expected 1", irq_low); end
        n_checks++;
        if (irqhist[n + 42] !== 1'b1) begin n_fail++; $display("FAIL single_irq_after: got %b expected 1", irqhist[n + 42]); end
    endtask

    task automatic test_decode();
        MemWrite = 1'b0;
        Addr = A_ST; #1;
        n_checks++;
        if (RdData !== 32'h0000_0002 || Sel !== 1'b1) begin n_fail++; $display("FAIL dec_status: got %h/%b expected 00000002/1", RdData, Sel); end
        Addr = 32'h0000_1007; #1;
        n_checks++;
        if (RdData !== 32'h0000_0002) begin n_fail++; $display("FAIL dec_lowbits: got %h expected 00000002", RdData); end
        Addr = A_OUT; #1;
        n_checks++;
        if (RdData !== 32'h0 || Sel !== 1'b0) begin n_fail++; $display("FAIL dec_outside: got %h/%b expected 00000000/0", RdData, Sel); end
        Addr = A_TX; #1;
        n_checks++;
        if (RdData !== 32'h0 || Sel !== 1'b1) begin n_fail++; $display("FAIL dec_txdata: got %h/%b expected 00000000/1", RdData, Sel); end
        Addr = 32'h0000_100C; #1;
        n_checks++;
        if (RdData !== 32'h0) begin n_fail++; $display("FAIL dec_reserved: got %h expected 00000000", RdData); end
    endtask

    task automatic test_ignored_writes();
        @(negedge clk); Addr = A_OUT; WriteData = 32'h55; MemWrite = 1'b1;
        @(negedge clk); Addr = A_RES;
        @(negedge clk); Addr = 32'h0000_0000;
        @(negedge clk); MemWrite = 1'b0;
        repeat (3) @(negedge clk);
        Addr = A_ST; #1;
        n_checks++;
        if (RdData !== 32'h0000_0002) begin n_fail++; $display("FAIL ignored_status: got %h expected 00000002", RdData); end
        n_checks++;
        if (tx !== 1'b1 || irq !== 1'b1) begin n_fail++; $display("FAIL ignored_line: got tx=%b irq=%b expected 1/1", tx, irq); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [39:0] v;
        logic idle_ok;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) n = cyc;
            Addr = A_TX; WriteData = 32'(i); MemWrite = 1'b1;
        end
        @(negedge clk);
        MemWrite = 1'b0; Addr = A_ST;
        #1;
        n_checks++;
        if (RdData !== 32'h0000_080D) begin n_fail++; $display("FAIL b2b_status_full: got %h expected 0000080d", RdData); end
        repeat (9 * FRAME) @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            gather(n + 2 + k * FRAME, v);
            n_checks++;
            if (v !== frame_bits(8'(k))) begin n_fail++; $display("FAIL b2b_frame%0d: got %h expected %h", k, v, frame_bits(8'(k))); end
        end
        idle_ok = 1'b1;
        for (int c = n + 362; c < n + 370; c++) if (txhist[c] !== 1'b1 || irqhist[c] !== 1'b1) idle_ok = 1'b0;
        n_checks++;
        if (idle_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_no_tenth: got %b expected 1", idle_ok); end
        #1;
        n_checks++;
        if (RdData !== 32'h0000_000A) begin n_fail++; $display("FAIL b2b_ovf_sticky: got %h expected 0000000a", RdData); end
        @(negedge clk); Addr = A_ST; WriteData = 32'h8; MemWrite = 1'b1;
        @(negedge clk); MemWrite = 1'b0;
        #1;
        n_checks++;
        if (RdData !== 32'h0000_0002) begin n_fail++; $display("FAIL b2b_ovf_clear: got %h expected 00000002", RdData); end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        logic quiet;
        logic [7:0] bytes [4];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) n = cyc;
            Addr = A_TX; WriteData = {24'h0, bytes[i]}; MemWrite = 1'b1;
        end
        @(negedge clk); MemWrite = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; Addr = A_ST;
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx: got %b expected 1", tx); end
        n_checks++;
        if (RdData !== 32'h0000_0002) begin n_fail++; $display("FAIL rst_mid_status: got %h expected 00000002", RdData); end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL rst_mid_irq: got %b expected 1", irq); end
        repeat (100) @(negedge clk);
        n_checks++;
        if (txhist[n + 12] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_was_data: got %b expected 0", txhist[n + 12]); end
        quiet = 1'b1;
        for (int c = n + 13; c < n + 112; c++) if (txhist[c] !== 1'b1) quiet = 1'b0;
        n_checks++;
        if (quiet !== 1'b1) begin n_fail++; $display("FAIL rst_mid_no_frames: got %b expected 1", quiet); end
    endtask

    task automatic test_store_on_stop();
        int n;
        logic [39:0] v;
        @(negedge clk);
        n = cyc;
        Addr = A_TX; WriteData = 32'h3C; MemWrite = 1'b1;
        @(negedge clk); MemWrite = 1'b0;
        repeat (40) @(negedge clk);
        Addr = A_TX; WriteData = 32'hC3; MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0; Addr = A_ST;
        #1;
        n_checks++;
        if (RdData !== 32'h0000_0100 || irq !== 1'b0) begin n_fail++; $display("FAIL stop_push: got %h irq=%b expected 00000100 irq=0", RdData, irq); end
        repeat (50) @(negedge clk);
        gather(n + 2, v);
        n_checks++;
        if (v !== frame_bits(8'h3C)) begin n_fail++; $display("FAIL stop_frame1: got %h expected %h", v, frame_bits(8'h3C)); end
        n_checks++;
        if (txhist[n + 42] !== 1'b1) begin n_fail++; $display("FAIL stop_gap: got %b expected 1", txhist[n + 42]); end
        gather(n + 43, v);
        n_checks++;
        if (v !== frame_bits(8'hC3)) begin n_fail++; $display("FAIL stop_frame2: got %h expected %h", v, frame_bits(8'hC3)); end
        n_checks++;
        if (irqhist[n + 83] !== 1'b1) begin n_fail++; $display("FAIL stop_irq_end: got %b expected 1", irqhist[n + 83]); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_decode();
        test_ignored_writes();
        test_back_to_back();
        test_reset_mid_frame();
        test_store_on_stop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
